// File: rtl/reg_status_pkg.sv
// rtl/reg_status_pkg.sv - shared register-status widths, tag constants and index types
package reg_status_pkg;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_REG_COUNT = 32;
    localparam int DEF_TAG_W     = 4;
    localparam int DEF_NUM_CKPT  = 4;

    localparam int REG_W  = $clog2(DEF_REG_COUNT);
    localparam int CKPT_W = $clog2(DEF_NUM_CKPT);

    typedef logic [REG_W-1:0]     reg_idx_t;
    typedef logic [DEF_TAG_W-1:0] tag_t;
    typedef logic [CKPT_W-1:0]    ckpt_idx_t;

    localparam tag_t NO_TAG = '0;

endpackage

// File: rtl/ckpt_ring_ctrl.sv
// rtl/ckpt_ring_ctrl.sv - head/tail/count bookkeeping for the rename checkpoint ring
module ckpt_ring_ctrl
    import reg_status_pkg::*;
#(
    parameter int NUM_CKPT = DEF_NUM_CKPT,
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          take_i,
    input  logic          release_i,
    input  logic          restore_i,
    input  logic [CW-1:0] restore_id_i,
    input  logic          flush_i,
    output logic          take_ok_o,
    output logic          live_o,
    output logic [CW-1:0] head_o,
    output logic [CW-1:0] tail_o,
    output logic [CW:0]   count_o,
    output logic          full_o
);

    logic [CW-1:0] head_q, head_d, tail_q, tail_d, rest_off;
    logic [CW:0]   count_q, count_d;
    logic          rel_ok;

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign full_o  = (count_q == (CW+1)'(NUM_CKPT));

    always_comb begin
        rel_ok    = release_i && (count_q != '0);
        // A release in the same cycle frees the head slot, so a take may still land when full.
        take_ok_o = take_i && (!full_o || rel_ok) && !restore_i && !flush_i;
        rest_off  = restore_id_i - head_q;
        live_o    = ({1'b0, rest_off} < count_q);
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (restore_i) begin
            if (live_o) begin
                tail_d  = restore_id_i;
                count_d = {1'b0, rest_off};
                if (release_i && (restore_id_i != head_q)) begin
                    head_d  = head_q + 1'b1;
                    count_d = count_d - 1'b1;
                end
            end
        end else begin
            if (take_ok_o) tail_d = tail_q + 1'b1;
            if (rel_ok)    head_d = head_q + 1'b1;
            count_d = count_q + (CW+1)'(take_ok_o) - (CW+1)'(rel_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_status_file_ckpt.sv
// rtl/reg_status_file_ckpt.sv - architectural register file with rename tags and checkpointed Q table
module reg_status_file_ckpt
    import reg_status_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int NUM_CKPT  = DEF_NUM_CKPT,
    localparam int RW = $clog2(REG_COUNT),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ren_valid,
    input  logic [RW-1:0]    ren_rd,
    input  logic [TAG_W-1:0] ren_tag,
    input  logic [RW-1:0]    rs1,
    input  logic [RW-1:0]    rs2,
    output logic [XLEN-1:0]  v1,
    output logic [XLEN-1:0]  v2,
    output logic [TAG_W-1:0] q1,
    output logic [TAG_W-1:0] q2,
    input  logic             cmt_valid,
    input  logic [RW-1:0]    cmt_rd,
    input  logic [TAG_W-1:0] cmt_tag,
    input  logic [XLEN-1:0]  cmt_data,
    input  logic             ckpt_take,
    output logic [CW-1:0]    ckpt_id,
    output logic             ckpt_full,
    input  logic             ckpt_release,
    input  logic             restore_valid,
    input  logic [CW-1:0]    restore_id,
    input  logic             flush_all
);

    localparam logic [TAG_W-1:0] NONE = TAG_W'(NO_TAG);

    logic [XLEN-1:0]  v_q    [REG_COUNT];
    logic [TAG_W-1:0] q_q    [REG_COUNT];
    logic [TAG_W-1:0] q_n    [REG_COUNT];
    logic [TAG_W-1:0] snap_q [NUM_CKPT][REG_COUNT];
    logic [TAG_W-1:0] snap_c [NUM_CKPT][REG_COUNT];

    logic          cmt_wr, ren_en, take_ok, live, restore_ok;
    logic [CW-1:0] head, tail;
    logic [CW:0]   count;

    assign cmt_wr     = cmt_valid && (cmt_rd != '0);
    assign ren_en     = ren_valid && (ren_rd != '0) && !restore_valid && !flush_all;
    assign restore_ok = restore_valid && live && !flush_all;
    assign ckpt_id    = tail;

    ckpt_ring_ctrl #(.NUM_CKPT(NUM_CKPT)) u_ring (
        .clk          (clk),
        .rst          (rst),
        .take_i       (ckpt_take),
        .release_i    (ckpt_release),
        .restore_i    (restore_valid),
        .restore_id_i (restore_id),
        .flush_i      (flush_all),
        .take_ok_o    (take_ok),
        .live_o       (live),
        .head_o       (head),
        .tail_o       (tail),
        .count_o      (count),
        .full_o       (ckpt_full)
    );

    // Operand read sees start-of-cycle state plus the commit; the same-cycle rename is not forwarded.
    always_comb begin
        v1 = '0;
        q1 = NONE;
        v2 = '0;
        q2 = NONE;
        if (rs1 != '0) begin
            v1 = (cmt_wr && cmt_rd == rs1) ? cmt_data : v_q[rs1];
            q1 = (cmt_wr && cmt_rd == rs1 && q_q[rs1] == cmt_tag) ? NONE : q_q[rs1];
        end
        if (rs2 != '0) begin
            v2 = (cmt_wr && cmt_rd == rs2) ? cmt_data : v_q[rs2];
            q2 = (cmt_wr && cmt_rd == rs2 && q_q[rs2] == cmt_tag) ? NONE : q_q[rs2];
        end
    end

    // Snapshots must drop committed tags too, or a restore would resurrect a dead producer.
    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            q_n[r] = q_q[r];
            if (cmt_wr && cmt_rd == RW'(r) && q_q[r] == cmt_tag) q_n[r] = NONE;
            if (ren_en && ren_rd == RW'(r)) q_n[r] = ren_tag;
            for (int k = 0; k < NUM_CKPT; k++) begin
                snap_c[k][r] = (cmt_wr && cmt_rd == RW'(r) && snap_q[k][r] == cmt_tag)
                             ? NONE : snap_q[k][r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                v_q[r] <= '0;
                q_q[r] <= NONE;
                for (int k = 0; k < NUM_CKPT; k++) snap_q[k][r] <= NONE;
            end
        end else begin
            if (cmt_wr) v_q[cmt_rd] <= cmt_data;
            for (int r = 0; r < REG_COUNT; r++) begin
                if (flush_all)       q_q[r] <= NONE;
                else if (restore_ok) q_q[r] <= snap_c[restore_id][r];
                else                 q_q[r] <= q_n[r];
                for (int k = 0; k < NUM_CKPT; k++) begin
                    snap_q[k][r] <= (take_ok && tail == CW'(k)) ? q_n[r] : snap_c[k][r];
                end
            end
        end
    end

    restore_live_a: assert property (@(posedge clk) disable iff (!rst)
        (restore_valid && !flush_all) |-> live);

endmodule

// File: tb/tb_reg_status_file_ckpt.sv
// tb/tb_reg_status_file_ckpt.sv - directed self-checking bench for reg_status_file_ckpt
module tb_reg_status_file_ckpt;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren_valid;
    logic [4:0]  ren_rd;
    logic [3:0]  ren_tag;
    logic [4:0]  rs1, rs2;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic        cmt_valid;
    logic [4:0]  cmt_rd;
    logic [3:0]  cmt_tag;
    logic [31:0] cmt_data;
    logic        ckpt_take;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        ckpt_release;
    logic        restore_valid;
    logic [1:0]  restore_id;
    logic        flush_all;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_status_file_ckpt dut (
        .clk(clk), .rst(rst),
        .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .rs1(rs1), .rs2(rs2), .v1(v1), .v2(v2), .q1(q1), .q2(q2),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
        .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_release(ckpt_release), .restore_valid(restore_valid), .restore_id(restore_id),
        .flush_all(flush_all)
    );

    task automatic idle();
        ren_valid = 0; ren_rd = 0; ren_tag = 0;
        cmt_valid = 0; cmt_rd = 0; cmt_tag = 0; cmt_data = 0;
        ckpt_take = 0; ckpt_release = 0; restore_valid = 0; restore_id = 0; flush_all = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
        ren_valid = 1; ren_rd = rd; ren_tag = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] d);
        cmt_valid = 1; cmt_rd = rd; cmt_tag = tag; cmt_data = d;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        rs1 = a; rs2 = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        rename(5'd2, 4'd1);
        ckpt_take = 1;
        tick();
        rst = 1;
        read(5'd2, 5'd5);
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL reset_q2 got %0h want 0", q1); end
        n_chk++; if (v2 !== 32'd0) begin n_fail++; $display("FAIL reset_v5 got %0h want 0", v2); end
        n_chk++; if (ckpt_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", ckpt_full); end
        n_chk++; if (ckpt_id !== 2'd0) begin n_fail++; $display("FAIL reset_ckpt_id got %0d want 0", ckpt_id); end
        n_chk++; if (dut.u_ring.count_q !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", dut.u_ring.count_q); end
    endtask

    task automatic test_commit();
        rename(5'd5, 4'd3);
        read(5'd1, 5'd5);
        n_chk++; if (q2 !== 4'd0) begin n_fail++; $display("FAIL no_ren_fwd got %0h want 0", q2); end
        tick();
        read(5'd5, 5'd0);
        n_chk++; if (q1 !== 4'd3) begin n_fail++; $display("FAIL renamed_q5 got %0h want 3", q1); end
        commit(5'd5, 4'd3, 32'hDEAD);
        read(5'd5, 5'd0);
        n_chk++; if (v1 !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_v got %0h want dead", v1); end
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL bypass_q got %0h want 0", q1); end
        tick();
        read(5'd5, 5'd0);
        n_chk++; if (v1 !== 32'hDEAD) begin n_fail++; $display("FAIL commit_v5 got %0h want dead", v1); end
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL commit_q5 got %0h want 0", q1); end
    endtask

    task automatic test_rename_wins();
        rename(5'd5, 4'd3);
        tick();
        commit(5'd5, 4'd3, 32'hBEEF);
        rename(5'd5, 4'd7);
        read(5'd0, 5'd5);
        n_chk++; if (q2 !== 4'd0) begin n_fail++; $display("FAIL rw_bypass_q got %0h want 0", q2); end
        tick();
        read(5'd5, 5'd0);
        n_chk++; if (v1 !== 32'hBEEF) begin n_fail++; $display("FAIL rw_v5 got %0h want beef", v1); end
        n_chk++; if (q1 !== 4'd7) begin n_fail++; $display("FAIL rw_q5 got %0h want 7", q1); end
        commit(5'd5, 4'd3, 32'h55);
        read(5'd5, 5'd0);
        n_chk++; if (q1 !== 4'd7) begin n_fail++; $display("FAIL stale_bypass_q got %0h want 7", q1); end
        tick();
        read(5'd5, 5'd0);
        n_chk++; if (v1 !== 32'h55) begin n_fail++; $display("FAIL stale_v5 got %0h want 55", v1); end
        n_chk++; if (q1 !== 4'd7) begin n_fail++; $display("FAIL stale_q5 got %0h want 7", q1); end
    endtask

    task automatic test_restore();
        flush_all = 1;
        tick();
        rename(5'd1, 4'd2);
        tick();
        ckpt_take = 1;
        tick();
        n_chk++; if (ckpt_id !== 2'd1) begin n_fail++; $display("FAIL take_id got %0d want 1", ckpt_id); end
        rename(5'd1, 4'd9);
        tick();
        read(5'd1, 5'd0);
        n_chk++; if (q1 !== 4'd9) begin n_fail++; $display("FAIL pre_restore_q1 got %0h want 9", q1); end
        restore_valid = 1; restore_id = 2'd0;
        rename(5'd1, 4'd12);
        tick();
        read(5'd1, 5'd0);
        n_chk++; if (q1 !== 4'd2) begin n_fail++; $display("FAIL restore_q1 got %0h want 2", q1); end
        n_chk++; if (dut.u_ring.count_q !== 3'd0) begin n_fail++; $display("FAIL restore_count got %0d want 0", dut.u_ring.count_q); end
        n_chk++; if (ckpt_id !== 2'd0) begin n_fail++; $display("FAIL restore_tail got %0d want 0", ckpt_id); end
    endtask

    task automatic test_snapshot_clear();
        rename(5'd4, 4'd5);
        tick();
        ckpt_take = 1;
        tick();
        commit(5'd4, 4'd5, 32'h44);
        tick();
        restore_valid = 1; restore_id = 2'd0;
        tick();
        read(5'd4, 5'd1);
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL snapclr_q4 got %0h want 0", q1); end
        n_chk++; if (v1 !== 32'h44) begin n_fail++; $display("FAIL snapclr_v4 got %0h want 44", v1); end
        n_chk++; if (q2 !== 4'd2) begin n_fail++; $display("FAIL snapclr_q1 got %0h want 2", q2); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) begin
            ckpt_take = 1;
            tick();
        end
        n_chk++; if (ckpt_full !== 1'b1) begin n_fail++; $display("FAIL full_after4 got %0b want 1", ckpt_full); end
        n_chk++; if (ckpt_id !== 2'd0) begin n_fail++; $display("FAIL wrap_tail got %0d want 0", ckpt_id); end
        ckpt_take = 1;
        tick();
        n_chk++; if (dut.u_ring.count_q !== 3'd4) begin n_fail++; $display("FAIL take5_count got %0d want 4", dut.u_ring.count_q); end
        n_chk++; if (ckpt_id !== 2'd0) begin n_fail++; $display("FAIL take5_tail got %0d want 0", ckpt_id); end
        ckpt_take = 1; ckpt_release = 1;
        rename(5'd6, 4'd8);
        tick();
        n_chk++; if (ckpt_full !== 1'b1) begin n_fail++; $display("FAIL reltake_full got %0b want 1", ckpt_full); end
        n_chk++; if (dut.u_ring.head_q !== 2'd1) begin n_fail++; $display("FAIL reltake_head got %0d want 1", dut.u_ring.head_q); end
        n_chk++; if (ckpt_id !== 2'd1) begin n_fail++; $display("FAIL reltake_tail got %0d want 1", ckpt_id); end
        rename(5'd6, 4'd10);
        tick();
        restore_valid = 1; restore_id = 2'd0;
        tick();
        read(5'd6, 5'd0);
        n_chk++; if (q1 !== 4'd8) begin n_fail++; $display("FAIL wrap_restore_q6 got %0h want 8", q1); end
        n_chk++; if (dut.u_ring.count_q !== 3'd3) begin n_fail++; $display("FAIL wrap_restore_count got %0d want 3", dut.u_ring.count_q); end
        n_chk++; if (ckpt_full !== 1'b0) begin n_fail++; $display("FAIL wrap_restore_full got %0b want 0", ckpt_full); end
        restore_valid = 1; restore_id = 2'd3; ckpt_release = 1;
        tick();
        read(5'd6, 5'd0);
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL restrel_q6 got %0h want 0", q1); end
        n_chk++; if (dut.u_ring.count_q !== 3'd1) begin n_fail++; $display("FAIL restrel_count got %0d want 1", dut.u_ring.count_q); end
        n_chk++; if (dut.u_ring.head_q !== 2'd2) begin n_fail++; $display("FAIL restrel_head got %0d want 2", dut.u_ring.head_q); end
        n_chk++; if (ckpt_id !== 2'd3) begin n_fail++; $display("FAIL restrel_tail got %0d want 3", ckpt_id); end
    endtask

    task automatic test_flush();
        rename(5'd3, 4'd6);
        tick();
        ckpt_take = 1;
        tick();
        flush_all = 1; ckpt_take = 1; ckpt_release = 1;
        commit(5'd3, 4'd9, 32'h11);
        rename(5'd7, 4'd2);
        tick();
        read(5'd3, 5'd7);
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL flush_q3 got %0h want 0", q1); end
        n_chk++; if (v1 !== 32'h11) begin n_fail++; $display("FAIL flush_v3 got %0h want 11", v1); end
        n_chk++; if (q2 !== 4'd0) begin n_fail++; $display("FAIL flush_q7 got %0h want 0", q2); end
        n_chk++; if (dut.u_ring.count_q !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", dut.u_ring.count_q); end
        n_chk++; if (ckpt_id !== 2'd0) begin n_fail++; $display("FAIL flush_tail got %0d want 0", ckpt_id); end
        ckpt_release = 1;
        tick();
        n_chk++; if (dut.u_ring.count_q !== 3'd0) begin n_fail++; $display("FAIL empty_rel_count got %0d want 0", dut.u_ring.count_q); end
        n_chk++; if (dut.u_ring.head_q !== 2'd0) begin n_fail++; $display("FAIL empty_rel_head got %0d want 0", dut.u_ring.head_q); end
        rename(5'd0, 4'd4);
        commit(5'd0, 4'd0, 32'hFF);
        tick();
        read(5'd0, 5'd0);
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL x0_q got %0h want 0", q1); end
        n_chk++; if (v1 !== 32'd0) begin n_fail++; $display("FAIL x0_v got %0h want 0", v1); end
    endtask

    task automatic test_reset_midop();
        rename(5'd9, 4'd5);
        tick();
        ckpt_take = 1;
        tick();
        rst = 0;
        commit(5'd9, 4'd5, 32'h99);
        ckpt_take = 1;
        tick();
        rst = 1;
        read(5'd9, 5'd0);
        n_chk++; if (v1 !== 32'd0) begin n_fail++; $display("FAIL midrst_v9 got %0h want 0", v1); end
        n_chk++; if (q1 !== 4'd0) begin n_fail++; $display("FAIL midrst_q9 got %0h want 0", q1); end
        n_chk++; if (dut.u_ring.count_q !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", dut.u_ring.count_q); end
    endtask

    initial begin
        rs1 = 0; rs2 = 0;
        test_reset();
        test_commit();
        test_rename_wins();
        test_restore();
        test_snapshot_clear();
        test_full_wrap();
        test_flush();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
